// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe: fetch side drives operands, writeback side takes results.
interface alu_pipe_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             zero;
  logic             negative;
  logic             overflow;

  modport master (
    output in_valid, a, b, alu_sel, out_ready,
    input  in_ready, out_valid, result, carry_out, zero, negative, overflow
  );

  modport slave (
    input  in_valid, a, b, alu_sel, out_ready,
    output in_ready, out_valid, result, carry_out, zero, negative, overflow
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides; single-cycle ops plus optional shift-add multiply.
// Define ALU_MUL_EN to enable opcode 11 (unsigned multiply); otherwise opcode 11 is reserved.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int M   = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_reg, state_next;
  logic             accept, is_mul, load_alu, load_mul;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [WIDTH:0]   wide;
  logic [SHW-1:0]   shamt;
  logic             big_shift;
  logic [WIDTH-1:0] result_reg;
  logic             carry_reg, zero_reg, neg_reg, ovf_reg;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] hi_reg, lo_reg, mcand_reg;
  logic [SHW-1:0]   cnt_reg;
  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             mul_last;

  assign is_mul   = (bus.alu_sel == 4'd11);
  assign mul_last = (state_reg == BUSY) && (cnt_reg == SHW'(WIDTH - 1));
  // One shift-add step: add multiplicand into the high half when the multiplier LSB is set, then shift right.
  assign step_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mcand_reg} : '0);
  assign step_hi  = step_sum[WIDTH:1];
  assign step_lo  = {step_sum[0], lo_reg[WIDTH-1:1]};
`else
  assign is_mul = 1'b0;
`endif

  assign accept   = bus.in_valid && bus.in_ready;
  assign load_alu = accept && !is_mul;
  assign load_mul = accept && is_mul;

  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    wide      = '0;
    shamt     = bus.b[SHW-1:0];
    big_shift = (bus.b >= WIDTH'(WIDTH));
    case (bus.alu_sel)
      4'd0: alu_res = bus.a | bus.b;
      4'd1: alu_res = bus.a & bus.b;
      4'd2: begin
        wide    = {1'b0, bus.a} + {1'b0, bus.b};
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
        alu_v   = (bus.a[M] == bus.b[M]) && (wide[M] != bus.a[M]);
      end
      4'd3: begin
        wide    = {1'b0, bus.a} - {1'b0, bus.b};
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
        alu_v   = (bus.a[M] != bus.b[M]) && (wide[M] != bus.a[M]);
      end
      4'd4: alu_res = bus.a ^ bus.b;
      4'd5: alu_res = ~(bus.a ^ bus.b);
      4'd6: alu_res = ~(bus.a & bus.b);
      4'd7: alu_res = ~(bus.a | bus.b);
      // Shifts use a guard bit so the last bit shifted out lands in a fixed position.
      4'd8: if (!big_shift) begin
        wide    = {1'b0, bus.a} << shamt;
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
      end
      4'd9: if (!big_shift) begin
        wide    = {bus.a, 1'b0} >> shamt;
        alu_res = wide[WIDTH:1];
        alu_c   = wide[0];
      end
      4'd10: begin
        if (big_shift) begin
          alu_res = {WIDTH{bus.a[M]}};
          alu_c   = bus.a[M];
        end else begin
          wide    = $signed({bus.a, 1'b0}) >>> shamt;
          alu_res = wide[WIDTH:1];
          alu_c   = wide[0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = is_mul ? BUSY : DONE;
      end
`ifdef ALU_MUL_EN
      BUSY: if (mul_last) state_next = DONE;
`endif
      DONE: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) state_next = is_mul ? BUSY : DONE;
          else              state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= '0;
      carry_reg  <= 1'b0;
      zero_reg   <= 1'b0;
      neg_reg    <= 1'b0;
      ovf_reg    <= 1'b0;
`ifdef ALU_MUL_EN
      hi_reg     <= '0;
      lo_reg     <= '0;
      mcand_reg  <= '0;
      cnt_reg    <= '0;
`endif
    end else begin
      if (load_alu) begin
        result_reg <= alu_res;
        carry_reg  <= alu_c;
        zero_reg   <= (alu_res == '0);
        neg_reg    <= alu_res[M];
        ovf_reg    <= alu_v;
      end
`ifdef ALU_MUL_EN
      if (load_mul) begin
        hi_reg    <= '0;
        lo_reg    <= bus.b;
        mcand_reg <= bus.a;
        cnt_reg   <= '0;
      end else if (state_reg == BUSY) begin
        hi_reg  <= step_hi;
        lo_reg  <= step_lo;
        cnt_reg <= cnt_reg + 1'b1;
        if (mul_last) begin
          result_reg <= step_lo;
          carry_reg  <= |step_hi;
          zero_reg   <= (step_lo == '0);
          neg_reg    <= step_lo[M];
          ovf_reg    <= 1'b0;
        end
      end
`endif
    end
  end

  assign bus.result    = result_reg;
  assign bus.carry_out = carry_reg;
  assign bus.zero      = zero_reg;
  assign bus.negative  = neg_reg;
  assign bus.overflow  = ovf_reg;
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU.
- Adds a width parameter, a 4-bit opcode space (shifts, optional multiply), full status flags and valid/ready handshakes on both sides.
- Sits between the operand-fetch stage and the writeback stage of the datapath.
- Single-cycle ops have 1-cycle latency; multiply is multi-cycle.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4).
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and opcode valid.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (shift amount for shifts).
- alu_sel  input  4  opcode.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  result.
- carry_out  output  1  carry/borrow/shift-out/mul-high flag.
- zero  output  1  result == 0.
- negative  output  1  result[WIDTH-1].
- overflow  output  1  signed overflow (ADD/SUB only, else 0).

Behaviour:
- Reset: async on rst_n low. State=IDLE; result=0; carry_out, zero, negative, overflow, out_valid = 0. in_ready is 1 once out of reset. Reset mid-MUL aborts the operation with no output.
- Opcodes:
  - 0 OR; 1 AND.
  - 2 ADD: {carry,result}=a+b.
  - 3 SUB: {carry,result}=a-b, zero-extended to WIDTH+1, so carry=1 iff a<b unsigned.
  - 4 XOR; 5 XNOR; 6 NAND; 7 NOR.
  - 8 SHL; 9 SHR (logical); 10 ASR.
  - 11 MUL (see Optional Feature).
  - 12-15 reserved: result=0, carry=0, 1-cycle.
- Flags:
  - carry_out=0 for all logic ops.
  - overflow=1 on ADD iff a,b same sign and result sign differs; on SUB iff a,b differ in sign and result sign differs from a.
  - zero and negative are always derived from the registered result.
- Shifts: the amount is the full b value.
  - b=0: result=a, carry=0.
  - 1<=b<=WIDTH-1: carry = last bit shifted out.
  - b>=WIDTH: SHL/SHR give result=0, carry=0; ASR gives all bits = a[WIDTH-1], carry=a[WIDTH-1].
- Handshake: a transfer occurs on in_valid&&in_ready; out transfer on out_valid&&out_ready. Inputs are sampled only at transfer; held values are ignored otherwise.
- FSM:
  - IDLE: in_ready=1. Single-cycle op accepted -> DONE next cycle with result registered. MUL accepted -> BUSY.
  - BUSY: in_ready=0. Shift-add one bit per cycle for WIDTH cycles, then -> DONE.
  - DONE: out_valid=1; outputs held stable until out_ready. in_ready=out_ready.
    - Out transfer with no new input -> IDLE.
    - Out transfer with a simultaneous single-cycle input -> stay in DONE with the new result next cycle (back-to-back, 1 op/cycle throughput).
    - Out transfer with a simultaneous MUL -> BUSY, out_valid=0.
- Latency from accept to out_valid: 1 cycle for non-MUL; WIDTH+1 cycles for MUL.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: opcode 11 is unsigned multiply via the BUSY state.
  - result = low WIDTH bits of a*b.
  - carry_out=1 iff the high WIDTH bits are nonzero.
  - overflow=0.
- Undefined: no multiplier or BUSY logic is synthesised. Opcode 11 behaves as reserved: result=0, zero=1, 1-cycle latency.

Test Plan:
- Reset release, then WIDTH=8, op2 a=0xF0 b=0x20, out_ready=1 -> 1 cycle later result=0x10, carry=1, zero=0, overflow=0.
- op3 a=0x05 b=0x07 -> result=0xFE, carry=1, negative=1. op2 a=0x7F b=0x01 -> result=0x80, overflow=1.
- op8 a=0x81 b=1 -> result=0x02, carry=1. op10 a=0x80 b=9 -> result=0xFF, carry=1. op9 a=0x81 b=0 -> result=0x81, carry=0.
- ALU_MUL_EN defined, op11 a=0x10 b=0x11 -> in_ready=0 for 8 cycles; out_valid at cycle 9 with result=0x10, carry=1. Undefined -> result=0, zero=1 at cycle 1.
- out_ready=0 for 5 cycles after an op1 result -> result and flags stable, in_ready=0. Then out_ready=1 with op0 presented the same cycle -> new result next cycle, no bubble.
- rst_n asserted during MUL BUSY -> out_valid=0 and flags=0 immediately. After release, in_ready=1 and the aborted op produces no output.
